// File: rtl/cg_enable_ctrl.sv
// Idle-detection clock-gate enable controller with a valid/ready hold-off during wake.
// Optional statistics counters (gated_cycles, wake_events) are enabled by defining CG_STATS_EN.
//
// state | meaning
// RUN   | clock on, accepting requests
// DRAIN | clock on, counting consecutive idle cycles
// OFF   | clock gated, requests held off
// WAKE  | clock on, settling before requests are accepted
module cg_enable_ctrl #(
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              busy,
    input  logic              force_on,
    output logic              gate_en,
    output logic              gated
`ifdef CG_STATS_EN
    ,
    output logic [31:0]       gated_cycles,
    output logic [15:0]       wake_events
`endif
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_OFF   = 2'd2;
    localparam logic [1:0] ST_WAKE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gate_en;
    logic             r_req_ready;
    logic             r_gated;

    logic             w_act;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_act = req_valid | busy | force_on;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_act) begin
                    w_cnt_nxt = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_DRAIN: begin
                // Activity on the final idle cycle still wins and keeps the clock on.
                if (w_act) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == IDLE_LAST) begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_OFF: begin
                if (w_act) begin
                    w_state_nxt = ST_WAKE;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_WAKE: begin
                if (r_cnt == WAKE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so every output is a plain flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_cnt       <= CNT_ZERO;
            r_gate_en   <= 1'b1;
            r_req_ready <= 1'b1;
            r_gated     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gate_en   <= (w_state_nxt != ST_OFF);
            r_req_ready <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            r_gated     <= (w_state_nxt == ST_OFF);
        end
    end

    assign gate_en   = r_gate_en;
    assign req_ready = r_req_ready;
    assign gated     = r_gated;

`ifdef CG_STATS_EN
    logic [31:0] r_gated_cycles;
    logic [15:0] r_wake_events;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gated_cycles <= '0;
            r_wake_events  <= '0;
        end else begin
            if ((r_state == ST_OFF) && (r_gated_cycles != 32'hFFFF_FFFF)) begin
                r_gated_cycles <= r_gated_cycles + 32'd1;
            end
            if ((r_state == ST_OFF) && (w_state_nxt == ST_WAKE) && (r_wake_events != 16'hFFFF)) begin
                r_wake_events <= r_wake_events + 16'd1;
            end
        end
    end

    assign gated_cycles = r_gated_cycles;
    assign wake_events  = r_wake_events;
`endif

endmodule

// File: tb/tb_cg_enable_ctrl.sv
// Scoreboard bench for cg_enable_ctrl: directed per-cycle vectors push expected outputs,
// a monitor pops and compares them after each rising edge.
module tb_cg_enable_ctrl;

    logic clk;
    logic rst_n;
    logic req_valid;
    logic req_ready;
    logic busy;
    logic force_on;
    logic gate_en;
    logic gated;
`ifdef CG_STATS_EN
    logic [31:0] gated_cycles;
    logic [15:0] wake_events;
`endif

    cg_enable_ctrl #(
        .IDLE_CYCLES (4),
        .WAKE_CYCLES (2),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .busy      (busy),
        .force_on  (force_on),
        .gate_en   (gate_en),
        .gated     (gated)
`ifdef CG_STATS_EN
        ,
        .gated_cycles (gated_cycles),
        .wake_events  (wake_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic rst;
        logic g;
        logic r;
        logic gt;
    } exp_t;

    // {rst_n, req_valid, busy, force_on, exp gate_en, exp req_ready, exp gated}
    logic [6:0] vecs[$];
    exp_t       sb_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         vec_idx  = 0;
    int         n_xfer   = 0;

    task automatic add(input int n, input logic rst, input logic v, input logic b,
                       input logic f, input logic g, input logic r, input logic gt);
        for (int i = 0; i < n; i++) vecs.push_back({rst, v, b, f, g, r, gt});
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; busy = 1'b0; force_on = 1'b0;
        // reset held 3 edges, then 4 idle edges close the gate
        add(3, 0, 0, 0, 0, 1, 1, 0);
        add(3, 1, 0, 0, 0, 1, 1, 0);
        add(2, 1, 0, 0, 0, 0, 0, 1);
        // wake via req_valid: two WAKE cycles, then ready, transfer on the next edge
        add(2, 1, 1, 0, 0, 1, 0, 0);
        add(2, 1, 1, 0, 0, 1, 1, 0);
        // near-miss idle run, then a fresh 4-cycle idle run
        add(3, 1, 0, 0, 0, 1, 1, 0);
        add(1, 1, 1, 0, 0, 1, 1, 0);
        add(3, 1, 0, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        // force_on from OFF, held 20 cycles
        add(2, 1, 0, 0, 1, 1, 0, 0);
        add(18, 1, 0, 0, 1, 1, 1, 0);
        // busy in DRAIN restarts the idle count
        add(2, 1, 0, 0, 0, 1, 1, 0);
        add(1, 1, 0, 1, 0, 1, 1, 0);
        add(3, 1, 0, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        // reset at WAKE cycle 1
        add(1, 1, 1, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 1, 1, 0);
        add(3, 1, 0, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        // reset from OFF
        add(1, 0, 0, 0, 0, 1, 1, 0);
        add(3, 1, 0, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1);
        // busy in OFF wakes the block
        add(1, 1, 0, 1, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 1, 1, 0);
        // gate again and stay off 10 cycles
        add(3, 1, 0, 0, 0, 1, 1, 0);
        add(10, 1, 0, 0, 0, 0, 0, 1);

        foreach (vecs[k]) begin
            @(negedge clk);
            {rst_n, req_valid, busy, force_on} = vecs[k][6:3];
            sb_q.push_back('{rst: vecs[k][6], g: vecs[k][2], r: vecs[k][1], gt: vecs[k][0]});
            #4;
            if (rst_n && req_valid && req_ready) n_xfer++;
        end

        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        checks++;
        if (n_xfer != 2) begin
            failures++;
            $display("FAIL transfer_count: got %0d, required 2", n_xfer);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

`ifdef CG_STATS_EN
    logic [31:0] m_gc = '0;
    logic [15:0] m_we = '0;
    logic        m_prev_gt = 1'b0;
`endif

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({gate_en, req_ready, gated} !== {e.g, e.r, e.gt}) begin
                    failures++;
                    $display("FAIL vec%0d outputs: got gate_en=%b req_ready=%b gated=%b, required %b %b %b",
                             vec_idx, gate_en, req_ready, gated, e.g, e.r, e.gt);
                end
`ifdef CG_STATS_EN
                if (!e.rst) begin
                    m_gc = '0;
                    m_we = '0;
                end else begin
                    if (m_prev_gt && m_gc != 32'hFFFF_FFFF) m_gc = m_gc + 32'd1;
                    if (m_prev_gt && !e.gt && m_we != 16'hFFFF) m_we = m_we + 16'd1;
                end
                m_prev_gt = e.gt;
                checks++;
                if ({gated_cycles, wake_events} !== {m_gc, m_we}) begin
                    failures++;
                    $display("FAIL vec%0d stats: got gated_cycles=%0d wake_events=%0d, required %0d %0d",
                             vec_idx, gated_cycles, wake_events, m_gc, m_we);
                end
`endif
                vec_idx++;
            end
        end
    end

endmodule
